// File: rtl/bomberman_draw_pkg.sv
// Shared constants and types for the Bomberman draw engine.
// Screen geometry, ROM selector codes, command and state encodings.
package bomberman_draw_pkg;

    localparam int COLOUR_W   = 9;
    localparam int SCREEN_W   = 160;
    localparam int SCREEN_H   = 120;
    localparam int SPRITE_DIM = 8;

    localparam logic [COLOUR_W-1:0] TRANSPARENT = 9'h1F8;

    localparam logic [1:0] MEM_TITLE  = 2'd0;
    localparam logic [1:0] MEM_STAGE  = 2'd1;
    localparam logic [1:0] MEM_WIN    = 2'd2;
    localparam logic [1:0] MEM_SPRITE = 2'd3;

    typedef enum logic [3:0] {
        CMD_NONE,
        CMD_PRINT,
        CMD_STAGE,
        CMD_TILE,
        CMD_EXPLOSION,
        CMD_BOMB,
        CMD_P1,
        CMD_P1_HP,
        CMD_P2,
        CMD_P2_HP
    } cmd_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COPY,
        S_FLUSH,
        S_DONE
    } state_e;

    // y*160 + x using shifts only
    function automatic logic [14:0] screen_addr(
        input logic [8:0] x,
        input logic [7:0] y
    );
        return 15'({y, 7'd0}) + 15'({y, 5'd0}) + 15'(x);
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Column-inner, row-outer raster scan over a width x height block.
// Wraps to (0,0) when stepped on the last position.
module raster_counter (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       step,
    input  logic [7:0] width,
    input  logic [6:0] height,
    output logic [7:0] col,
    output logic [6:0] row,
    output logic       last
);

    logic col_end;
    logic row_end;

    assign col_end = (col == width - 8'd1);
    assign row_end = (row == height - 7'd1);
    assign last    = col_end & row_end;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            col <= '0;
            row <= '0;
        end else if (step) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? 7'd0 : row + 7'd1;
            end else begin
                col <= col + 8'd1;
            end
        end
    end

endmodule

// File: rtl/bomberman_draw_engine.sv
// Block copier: ROM -> frame buffer, or frame buffer -> VGA on print_screen.
// Define BOMBERMAN_DRAW_TRANSPARENCY_EN to skip colour-keyed sprite pixels.
module bomberman_draw_engine
    import bomberman_draw_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                copy_enable,
    input  logic [1:0]          memory_select,
    input  logic                draw_stage,
    input  logic                draw_tile,
    input  logic                draw_explosion,
    input  logic                draw_bomb,
    input  logic                draw_p1,
    input  logic                draw_p1_hp,
    input  logic                draw_p2,
    input  logic                draw_p2_hp,
    input  logic                print_screen,
    input  logic                black,
    input  logic [7:0]          obj_x,
    input  logic [6:0]          obj_y,
    input  logic [3:0]          sprite_id,
    output logic                finished,
    output logic [1:0]          rom_sel,
    output logic [14:0]         rom_addr,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic [14:0]         buf_addr,
    output logic [COLOUR_W-1:0] buf_wdata,
    output logic                buf_we,
    input  logic [COLOUR_W-1:0] buf_rdata,
    output logic [7:0]          vga_x,
    output logic [6:0]          vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

`ifdef BOMBERMAN_DRAW_TRANSPARENCY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    state_e state;
    state_e state_n;
    cmd_e   cmd_req;
    cmd_e   cmd_q;

    logic       accept;
    logic       issue;
    logic       hold;
    logic [7:0] ox_q;
    logic [6:0] oy_q;
    logic [3:0] sid_q;
    logic       blk_q;
    logic       full_q;
    logic       prn_q;

    logic [7:0] col;
    logic [6:0] row;
    logic       last;
    logic [7:0] blk_w;
    logic [6:0] blk_h;

    logic [8:0]  tx;
    logic [7:0]  ty;
    logic [14:0] tgt_addr;
    logic        in_range;

    // read stage: address on the ROM/buffer bus this cycle
    logic        rd_v;
    logic        rd_last;
    logic        rd_prn;
    logic        rd_inr;
    logic        rd_blk;
    logic        rd_spr;
    logic [7:0]  rd_x;
    logic [6:0]  rd_y;
    logic [14:0] rd_waddr;

    // write stage: read data is valid this cycle
    logic wr_v;
    logic wr_prn;
    logic wr_inr;
    logic wr_blk;
    logic wr_spr;
    logic key_hit;

    always_comb begin
        cmd_req = CMD_NONE;
        if (print_screen)
            cmd_req = CMD_PRINT;
        else if (copy_enable) begin
            if (draw_stage)          cmd_req = CMD_STAGE;
            else if (draw_tile)      cmd_req = CMD_TILE;
            else if (draw_explosion) cmd_req = CMD_EXPLOSION;
            else if (draw_bomb)      cmd_req = CMD_BOMB;
            else if (draw_p1)        cmd_req = CMD_P1;
            else if (draw_p1_hp)     cmd_req = CMD_P1_HP;
            else if (draw_p2)        cmd_req = CMD_P2;
            else if (draw_p2_hp)     cmd_req = CMD_P2_HP;
        end
    end

    always_comb begin
        hold = 1'b0;
        unique case (cmd_q)
            CMD_PRINT:     hold = print_screen;
            CMD_STAGE:     hold = copy_enable & draw_stage;
            CMD_TILE:      hold = copy_enable & draw_tile;
            CMD_EXPLOSION: hold = copy_enable & draw_explosion;
            CMD_BOMB:      hold = copy_enable & draw_bomb;
            CMD_P1:        hold = copy_enable & draw_p1;
            CMD_P1_HP:     hold = copy_enable & draw_p1_hp;
            CMD_P2:        hold = copy_enable & draw_p2;
            CMD_P2_HP:     hold = copy_enable & draw_p2_hp;
            default:       hold = 1'b0;
        endcase
    end

    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        issue    = 1'b0;
        finished = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (cmd_req != CMD_NONE) begin
                    accept  = 1'b1;
                    state_n = S_COPY;
                end
            end
            S_COPY: begin
                if (!hold)
                    state_n = S_IDLE;
                else if (rd_v && rd_last)
                    state_n = S_FLUSH;
                else
                    issue = 1'b1;
            end
            S_FLUSH: state_n = S_DONE;
            S_DONE: begin
                finished = 1'b1;
                state_n  = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_q   <= CMD_NONE;
            rom_sel <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            sid_q   <= '0;
            blk_q   <= 1'b0;
            full_q  <= 1'b0;
        end else if (accept) begin
            cmd_q   <= cmd_req;
            rom_sel <= memory_select;
            sid_q   <= sprite_id;
            blk_q   <= black;
            if (cmd_req == CMD_PRINT || cmd_req == CMD_STAGE) begin
                full_q <= 1'b1;
                ox_q   <= '0;
                oy_q   <= '0;
            end else begin
                full_q <= 1'b0;
                ox_q   <= obj_x;
                oy_q   <= obj_y;
            end
        end
    end

    assign prn_q = (cmd_q == CMD_PRINT);
    assign blk_w = full_q ? 8'(SCREEN_W) : 8'(SPRITE_DIM);
    assign blk_h = full_q ? 7'(SCREEN_H) : 7'(SPRITE_DIM);

    raster_counter u_scan (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept),
        .step   (issue),
        .width  (blk_w),
        .height (blk_h),
        .col    (col),
        .row    (row),
        .last   (last)
    );

    assign tx       = {1'b0, ox_q} + {1'b0, col};
    assign ty       = {1'b0, oy_q} + {1'b0, row};
    assign tgt_addr = screen_addr(tx, ty);
    assign in_range = (tx < 9'(SCREEN_W)) && (ty < 8'(SCREEN_H));

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_v     <= 1'b0;
            rd_last  <= 1'b0;
            rd_prn   <= 1'b0;
            rd_inr   <= 1'b0;
            rd_blk   <= 1'b0;
            rd_spr   <= 1'b0;
            rd_x     <= '0;
            rd_y     <= '0;
            rd_waddr <= '0;
            rom_addr <= '0;
        end else begin
            rd_v <= issue;
            if (issue) begin
                rd_last  <= last;
                rd_prn   <= prn_q;
                rd_inr   <= in_range;
                rd_blk   <= blk_q;
                rd_spr   <= (rom_sel == MEM_SPRITE) && !blk_q && !prn_q;
                rd_x     <= tx[7:0];
                rd_y     <= ty[6:0];
                rd_waddr <= tgt_addr;
                if (!prn_q) begin
                    if (!full_q && rom_sel == MEM_SPRITE)
                        rom_addr <= 15'({sid_q, row[2:0], col[2:0]});
                    else
                        rom_addr <= tgt_addr;
                end
            end
        end
    end

    // buf_addr carries read addresses on print_screen, write addresses otherwise
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_v     <= 1'b0;
            wr_prn   <= 1'b0;
            wr_inr   <= 1'b0;
            wr_blk   <= 1'b0;
            wr_spr   <= 1'b0;
            vga_x    <= '0;
            vga_y    <= '0;
            buf_addr <= '0;
        end else begin
            wr_v <= rd_v;
            if (rd_v) begin
                wr_prn <= rd_prn;
                wr_inr <= rd_inr;
                wr_blk <= rd_blk;
                wr_spr <= rd_spr;
            end
            if (rd_v && rd_prn) begin
                vga_x <= rd_x;
                vga_y <= rd_y;
            end
            if (issue && prn_q)
                buf_addr <= tgt_addr;
            else if (rd_v && !rd_prn)
                buf_addr <= rd_waddr;
        end
    end

    assign key_hit    = KEY_EN && wr_spr && (rom_data == TRANSPARENT);
    assign buf_we     = wr_v & ~wr_prn & wr_inr & ~key_hit;
    assign buf_wdata  = (wr_v & ~wr_prn & ~wr_blk) ? rom_data : '0;
    assign vga_plot   = wr_v & wr_prn;
    assign vga_colour = (vga_plot & ~wr_blk) ? buf_rdata : '0;

endmodule
